// File: rtl/binary_game_core_if.sv
// Signal bundle between the binary guessing game core and its board-level harness.
// Handshake: start is a one-cycle strobe sampled on every rising clk edge with no ready
// response (the core acts on it only in IDLE/OVER); all core outputs are registered and
// valid every cycle, and hit_p/timeout_p are one-cycle event strobes.
interface binary_game_core_if #(
    parameter int SW_W = 8,
    parameter int NDIG = 4
);
    logic            start;
    logic [SW_W-1:0] sw;
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic [SW_W-1:0] target;
    logic [7:0]      score;
    logic [1:0]      state;
    logic            hit_p;
    logic            timeout_p;

    modport master (
        output start, sw,
        input  an, seg, target, score, state, hit_p, timeout_p
    );

    modport slave (
        input  start, sw,
        output an, seg, target, score, state, hit_p, timeout_p
    );
endinterface

// File: rtl/binary_game_core.sv
// Binary guessing game: match a pseudo-random target on the switches before the round
// timer expires; the round limit shrinks with score, and a scanned 7-segment display shows progress.
module binary_game_core #(
    parameter int          SW_W        = 8,
    parameter int          NDIG        = 4,
    parameter int          TICK_DIV    = 100000000,
    parameter int          ROUND_TICKS = 10,
    parameter int          STEP_TICKS  = 1,
    parameter int          MIN_TICKS   = 3,
    parameter int          HOLD_CYCLES = 3,
    parameter int          SCAN_DIV    = 100000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               btnR,
    binary_game_core_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    localparam int TMAX = (ROUND_TICKS > MIN_TICKS) ? ROUND_TICKS : MIN_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW   = $clog2(HOLD_CYCLES + 1);
    localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int TNIB = SW_W / 4;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]      state_q, state_d;
    logic [7:0]      score_q, score_d;
    logic [SW_W-1:0] target_q, target_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [MW-1:0]   match_q, match_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            hit_q, hit_d;
    logic            timeout_q, timeout_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            tick;
    logic [31:0]     disp_val;
    logic [3:0]      disp_nib;
    logic            disp_on;

    // Round limit in ticks; the subtraction is guarded so a high score clamps instead of wrapping.
    function automatic logic [TW-1:0] limit_for(input logic [7:0] s);
        logic [31:0] dec;
        dec = 32'(s) * 32'(STEP_TICKS);
        if (ROUND_TICKS <= MIN_TICKS || dec >= 32'(ROUND_TICKS - MIN_TICKS))
            return TW'(MIN_TICKS);
        return TW'(32'(ROUND_TICKS) - dec);
    endfunction

    // A freshly loaded target never equals the current guess, so a round cannot be won for free.
    function automatic logic [SW_W-1:0] pick_target(input logic [15:0] l, input logic [SW_W-1:0] g);
        logic [SW_W-1:0] t;
        t = l[SW_W-1:0];
        if (t == g) t[0] = ~t[0];
        return t;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick   = (presc_q == PW'(TICK_DIV - 1));
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        target_d  = target_q;
        timer_d   = timer_q;
        match_d   = match_q;
        presc_d   = presc_q;
        hit_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d  = PLAY;
                    score_d  = 8'd0;
                    target_d = pick_target(lfsr_q, bus.sw);
                    timer_d  = limit_for(8'd0);
                    presc_d  = '0;
                    match_d  = '0;
                end
            end
            PLAY: begin
                match_d = (bus.sw == target_q) ? match_q + MW'(1) : '0;
                if (tick) begin
                    presc_d = '0;
                    timer_d = timer_q - TW'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // A hit on the same edge the timer expires takes precedence.
                if (match_d == MW'(HOLD_CYCLES)) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                end else if (tick && timer_q == TW'(1)) begin
                    state_d   = OVER;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                target_d = pick_target(lfsr_q, bus.sw);
                timer_d  = limit_for(score_d);
                presc_d  = '0;
                match_d  = '0;
                state_d  = PLAY;
            end
        endcase
    end

    // Display registers are driven from next-state values so the digits track the visible state.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end
        disp_val = 32'(target_d);
        disp_on  = (32'(idx_d) < 32'(TNIB));
        if (state_d == OVER) begin
            disp_val = 32'(score_d);
            disp_on  = (32'(idx_d) < 32'd2);
        end
        disp_nib = disp_val[{idx_d, 2'b00} +: 4];
        seg_d    = disp_on ? hex7(disp_nib) : SEG_BLANK;
        if (state_d == IDLE) seg_d = SEG_DASH;
        an_d = ~(NDIG'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (btnR) begin
            state_q    <= IDLE;
            score_q    <= 8'd0;
            target_q   <= '0;
            timer_q    <= '0;
            match_q    <= '0;
            presc_q    <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            lfsr_q     <= SEED;
            hit_q      <= 1'b0;
            timeout_q  <= 1'b0;
            an_q       <= ~NDIG'(1);
            seg_q      <= SEG_DASH;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            target_q   <= target_d;
            timer_q    <= timer_d;
            match_q    <= match_d;
            presc_q    <= presc_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            lfsr_q     <= lfsr_d;
            hit_q      <= hit_d;
            timeout_q  <= timeout_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.score     = score_q;
    assign bus.target    = target_q;
    assign bus.hit_p     = hit_q;
    assign bus.timeout_p = timeout_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule

// File: tb/tb_binary_game_core.sv
// Directed plus randomized bench for binary_game_core against a cycle-level game model
// that tracks round deadlines and match run lengths rather than prescaler/timer registers.
module tb_binary_game_core;
    localparam int          SW_W        = 8;
    localparam int          NDIG        = 4;
    localparam int          TICK_DIV    = 2;
    localparam int          ROUND_TICKS = 6;
    localparam int          STEP_TICKS  = 2;
    localparam int          MIN_TICKS   = 3;
    localparam int          HOLD_CYCLES = 3;
    localparam int          SCAN_DIV    = 4;
    localparam logic [15:0] SEED        = 16'hACE1;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic btnR;
    always #5 clk = ~clk;

    binary_game_core_if #(.SW_W(SW_W), .NDIG(NDIG)) bus ();

    binary_game_core #(
        .SW_W(SW_W), .NDIG(NDIG), .TICK_DIV(TICK_DIV), .ROUND_TICKS(ROUND_TICKS),
        .STEP_TICKS(STEP_TICKS), .MIN_TICKS(MIN_TICKS), .HOLD_CYCLES(HOLD_CYCLES),
        .SCAN_DIV(SCAN_DIV), .SEED(SEED)
    ) dut (
        .clk(clk),
        .btnR(btnR),
        .bus(bus)
    );

    // ---------------- model / scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int m_state, m_score, m_run, m_deadline, k;
    logic [SW_W-1:0] m_target;
    logic [15:0]     m_lfsr;
    logic            m_hit, m_to;
    logic [1:0]      exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic load_round();
        int lim;
        m_target = m_lfsr[SW_W-1:0];
        if (m_target == bus.sw) m_target[0] = ~m_target[0];
        lim = ROUND_TICKS - m_score * STEP_TICKS;
        if (lim < MIN_TICKS) lim = MIN_TICKS;
        m_deadline = k + lim * TICK_DIV;
        m_run      = 0;
        m_state    = 1;
    endtask

    task automatic model_edge();
        if (btnR) begin
            m_state = 0; m_score = 0; m_target = '0; m_lfsr = SEED;
            m_hit = 1'b0; m_to = 1'b0; m_run = 0; k = 0;
        end else begin
            k++;
            m_hit = 1'b0;
            m_to  = 1'b0;
            if ((m_state == 0 || m_state == 3) && bus.start) begin
                m_score = 0;
                load_round();
            end else if (m_state == 1) begin
                m_run = (bus.sw == m_target) ? m_run + 1 : 0;
                if (m_run == HOLD_CYCLES) begin
                    m_state = 2; m_hit = 1'b1; exp_q.push_back(2'b01);
                end else if (k == m_deadline) begin
                    m_state = 3; m_to = 1'b1; exp_q.push_back(2'b10);
                end
            end else if (m_state == 2) begin
                if (m_score < 255) m_score++;
                load_round();
            end
            m_lfsr = lfsr_adv(m_lfsr);
        end
    endtask

    function automatic int cur_idx();
        return (k / SCAN_DIV) % NDIG;
    endfunction

    function automatic logic [6:0] exp_seg();
        int idx, ndig;
        logic [31:0] v;
        logic [3:0] nib;
        idx = cur_idx();
        if (m_state == 0) return DASH;
        if (m_state == 3) begin v = 32'(m_score); ndig = 2; end
        else begin v = 32'(m_target); ndig = SW_W / 4; end
        if (idx >= ndig) return BLANK;
        nib = 4'(v >> (4 * idx));
        return HEX_TAB[nib];
    endfunction

    function automatic logic [NDIG-1:0] exp_an();
        logic [NDIG-1:0] a;
        a = '1;
        a[cur_idx()] = 1'b0;
        return a;
    endfunction

    task automatic check_cycle();
        logic [1:0] ev;
        chk("state", bus.state, m_state);
        chk("score", bus.score, m_score);
        chk("target", bus.target, m_target);
        chk("hit_p", bus.hit_p, m_hit);
        chk("timeout_p", bus.timeout_p, m_to);
        chk("an", bus.an, exp_an());
        chk("seg", bus.seg, exp_seg());
        if (bus.hit_p === 1'b1 || bus.timeout_p === 1'b1) begin
            ev = {bus.timeout_p, bus.hit_p};
            if (exp_q.size() == 0) chk("event_unexpected", ev, 2'b00);
            else chk("event_kind", ev, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_timeout(input string tag, input int expect_cycles);
        int got;
        got = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.timeout_p === 1'b1) begin
                got = i;
                break;
            end
        end
        chk(tag, got, expect_cycles);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int sat_hits, seen0, seen1, waited;
        bit found;
        btnR = 1'b1;
        bus.start = 1'b0;
        bus.sw = '0;
        step();
        step();
        chk("reset_state", bus.state, 0);
        chk("reset_an", bus.an, 4'b1110);
        chk("reset_seg", bus.seg, DASH);
        btnR = 1'b0;

        // Hit after three matching cycles, then reload with score 1.
        pulse_start();
        bus.sw = m_target;
        step();
        step();
        chk("no_early_hit", bus.hit_p, 1'b0);
        step();
        chk("hit_on_third", bus.hit_p, 1'b1);
        step();
        chk("score_after_hit", bus.score, 1);
        chk("new_target_ne_sw", (bus.target != bus.sw), 1'b1);
        bus.sw = ~m_target;
        wait_timeout("timeout_after_reload_4", 8);

        // Fresh game from OVER with no match: timeout 12 cycles after load.
        bus.sw = '0;
        pulse_start();
        bus.sw = ~m_target;
        wait_timeout("timeout_round_6", 12);
        chk("over_state", bus.state, 3);
        for (int i = 0; i < 16; i++) step();

        // Broken run: 2 matches, 1 miss, 3 matches.
        pulse_start();
        bus.sw = m_target;
        step();
        step();
        bus.sw = ~m_target;
        step();
        bus.sw = m_target;
        step();
        step();
        chk("broken_run_no_hit", bus.hit_p, 1'b0);
        step();
        chk("broken_run_hit", bus.hit_p, 1'b1);
        step();
        bus.sw = ~m_target;
        wait_timeout("timeout_after_broken_run", 8);

        // Third match lands on the timer-expiry edge.
        pulse_start();
        bus.sw = ~m_target;
        for (int i = 0; i < 9; i++) step();
        bus.sw = m_target;
        step();
        step();
        step();
        chk("race_hit", bus.hit_p, 1'b1);
        chk("race_no_timeout", bus.timeout_p, 1'b0);
        step();

        // Reset together with start while playing.
        btnR = 1'b1;
        bus.start = 1'b1;
        step();
        btnR = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_state", bus.state, 0);
        chk("rst_start_score", bus.score, 0);
        chk("rst_start_an", bus.an, 4'b1110);
        chk("rst_start_seg", bus.seg, DASH);
        chk("rst_start_pulses", {bus.hit_p, bus.timeout_p}, 2'b00);

        // Run the score into saturation with stray start pulses.
        pulse_start();
        sat_hits = 0;
        for (int i = 0; i < 2000 && sat_hits < 262; i++) begin
            bus.sw = m_target;
            bus.start = ($urandom_range(0, 3) == 0);
            step();
            if (m_hit) sat_hits++;
        end
        bus.start = 1'b0;
        step();
        chk("score_saturated", bus.score, 255);
        bus.sw = ~m_target;
        wait_timeout("timeout_clamped_3", 6);

        // Random play with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            btnR = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 7) == 0);
            bus.sw = ($urandom_range(0, 3) != 0) ? m_target : SW_W'($urandom_range(0, 255));
            step();
        end
        btnR = 1'b0;
        bus.start = 1'b0;

        // Scan order after reset, then target 3C on digits 0 and 1.
        btnR = 1'b1;
        step();
        btnR = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("scan_an", bus.an, AN_SEQ[(j / 4) % 4]);
            step();
        end
        bus.sw = '0;
        found = 1'b0;
        for (waited = 0; waited < 30000; waited++) begin
            if ((m_state == 0 || m_state == 3) && m_lfsr[7:0] == 8'h3C &&
                (((k + 1) / 4) % 4 == 0 || ((k + 1) / 4) % 4 == 3)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("found_3c", found, 1'b1);
        pulse_start();
        chk("target_3c", bus.target, 8'h3C);
        seen0 = 0;
        seen1 = 0;
        for (int i = 0; i < 11; i++) begin
            if (cur_idx() == 0) begin chk("digit0_c", bus.seg, 7'b1000110); seen0++; end
            if (cur_idx() == 1) begin chk("digit1_3", bus.seg, 7'b0110000); seen1++; end
            step();
        end
        chk("digit0_seen", (seen0 > 0), 1'b1);
        chk("digit1_seen", (seen1 > 0), 1'b1);

        chk("event_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
